// File: rtl/apsk_frame_sequencer.sv
// APSK frame sequencer: per-symbol header/payload/pilot scheduling
// with a valid/ready descriptor handshake toward the modulator.
module apsk_frame_sequencer #(
  parameter int BITS_PER_SYMBOL_WIDTH  = 4,
  parameter int LENGTH_WIDTH           = 16,
  parameter int MAX_BITS_PER_SYMBOL    = 5,
  parameter int HEADER_BITS_PER_SYMBOL = 1,
  parameter int PILOT_BITS_PER_SYMBOL  = 2
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [BITS_PER_SYMBOL_WIDTH-1:0] cfg_bits_per_symbol,
  input  logic                             cfg_offset_symbol_enable,
  input  logic [LENGTH_WIDTH-1:0]          cfg_header_length,
  input  logic [LENGTH_WIDTH-1:0]          cfg_payload_length,
  input  logic [LENGTH_WIDTH-1:0]          cfg_pilot_interval,
  input  logic [LENGTH_WIDTH-1:0]          cfg_pilot_length,
  input  logic                             cfg_pilots_enable,
  input  logic                             cfg_continuous,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             sym_ready,
  output logic                             sym_valid,
  output logic [1:0]                       sym_source,
  output logic [BITS_PER_SYMBOL_WIDTH-1:0] sym_bits_per_symbol,
  output logic                             sym_offset_enable,
  output logic                             sym_first,
  output logic                             sym_last,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             cfg_error
);

  localparam int BW = BITS_PER_SYMBOL_WIDTH;
  localparam int LW = LENGTH_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PILOT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_bps;
  logic          r_off;
  logic [LW-1:0] r_hdr_len;
  logic [LW-1:0] r_pay_len;
  logic [LW-1:0] r_itv;
  logic [LW-1:0] r_pil_len;
  logic          r_pil_en;
  logic          r_cont;
  logic [LW-1:0] r_seg_cnt;
  logic [LW-1:0] r_pay_cnt;
  logic [LW-1:0] r_itv_cnt;
  logic          r_first;

  logic          r_sym_valid;
  logic [1:0]    r_sym_source;
  logic [BW-1:0] r_sym_bps;
  logic          r_sym_off;
  logic          r_sym_first;
  logic          r_sym_last;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_cfg_error;

  state_t        w_state_n;
  logic [BW-1:0] w_bps_n;
  logic          w_off_n;
  logic [LW-1:0] w_hdr_len_n;
  logic [LW-1:0] w_pay_len_n;
  logic [LW-1:0] w_itv_n;
  logic [LW-1:0] w_pil_len_n;
  logic          w_pil_en_n;
  logic          w_cont_n;
  logic [LW-1:0] w_seg_cnt_n;
  logic [LW-1:0] w_pay_cnt_n;
  logic [LW-1:0] w_itv_cnt_n;
  logic          w_first_n;
  logic          w_err_n;

  logic          w_legal;
  logic          w_acc;
  logic          w_launch;
  logic [LW-1:0] w_seg_inc;
  logic [LW-1:0] w_pay_inc;
  logic [LW-1:0] w_itv_inc;

  logic          w_o_valid;
  logic [1:0]    w_o_source;
  logic [BW-1:0] w_o_bps;
  logic          w_o_off;
  logic          w_o_last;

  // Configuration legality and handshake/counter helpers
  always_comb begin
    w_legal = (cfg_bits_per_symbol != '0) &&
              (cfg_bits_per_symbol <= BW'(MAX_BITS_PER_SYMBOL)) &&
              !(cfg_pilots_enable &&
                ((cfg_pilot_interval == '0) ||
                 (cfg_pilot_length == '0)));
    w_acc     = r_sym_valid && sym_ready;
    w_launch  = ((r_state == S_IDLE) && start) ||
                ((r_state == S_DONE) && r_cont);
    w_seg_inc = r_seg_cnt + 1'b1;
    w_pay_inc = r_pay_cnt + 1'b1;
    w_itv_inc = r_itv_cnt + 1'b1;
  end

  // Next-state, latched-config and counter logic
  always_comb begin
    w_state_n   = r_state;
    w_bps_n     = r_bps;
    w_off_n     = r_off;
    w_hdr_len_n = r_hdr_len;
    w_pay_len_n = r_pay_len;
    w_itv_n     = r_itv;
    w_pil_len_n = r_pil_len;
    w_pil_en_n  = r_pil_en;
    w_cont_n    = r_cont;
    w_seg_cnt_n = r_seg_cnt;
    w_pay_cnt_n = r_pay_cnt;
    w_itv_cnt_n = r_itv_cnt;
    w_first_n   = r_first;
    w_err_n     = 1'b0;

    case (r_state)
      S_HEADER: begin
        if (w_acc) begin
          w_first_n = 1'b0;
          if (w_seg_inc == r_hdr_len) begin
            w_seg_cnt_n = '0;
            w_state_n   = (r_pay_len != '0) ? S_PAYLOAD
                                            : S_DONE;
          end else begin
            w_seg_cnt_n = w_seg_inc;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_acc) begin
          w_first_n   = 1'b0;
          w_pay_cnt_n = w_pay_inc;
          w_itv_cnt_n = w_itv_inc;
          if (w_pay_inc == r_pay_len) begin
            w_state_n = S_DONE;
          end else if (r_pil_en && (w_itv_inc == r_itv)) begin
            w_state_n   = S_PILOT;
            w_seg_cnt_n = '0;
          end
        end
      end
      S_PILOT: begin
        if (w_acc) begin
          if (w_seg_inc == r_pil_len) begin
            w_seg_cnt_n = '0;
            w_itv_cnt_n = '0;
            w_state_n   = S_PAYLOAD;
          end else begin
            w_seg_cnt_n = w_seg_inc;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Frame (re)start: latch the whole config for this frame
    if (w_launch) begin
      if (w_legal) begin
        w_bps_n     = cfg_bits_per_symbol;
        w_off_n     = cfg_offset_symbol_enable;
        w_hdr_len_n = cfg_header_length;
        w_pay_len_n = cfg_payload_length;
        w_itv_n     = cfg_pilot_interval;
        w_pil_len_n = cfg_pilot_length;
        w_pil_en_n  = cfg_pilots_enable;
        w_cont_n    = cfg_continuous;
        w_seg_cnt_n = '0;
        w_pay_cnt_n = '0;
        w_itv_cnt_n = '0;
        w_first_n   = 1'b1;
        if (cfg_header_length != '0) begin
          w_state_n = S_HEADER;
        end else if (cfg_payload_length != '0) begin
          w_state_n = S_PAYLOAD;
        end else begin
          w_state_n = S_DONE;
        end
      end else begin
        w_err_n   = 1'b1;
        w_state_n = S_IDLE;
      end
    end

    // Abort wins over everything outside IDLE
    if (abort && (r_state != S_IDLE)) begin
      w_state_n = S_IDLE;
      w_err_n   = 1'b0;
    end
  end

  // Descriptor for the symbol presented after the next edge
  always_comb begin
    w_o_valid  = 1'b0;
    w_o_source = 2'd0;
    w_o_bps    = '0;
    w_o_off    = 1'b0;
    w_o_last   = 1'b0;
    case (w_state_n)
      S_HEADER: begin
        w_o_valid  = 1'b1;
        w_o_source = 2'd0;
        w_o_bps    = BW'(HEADER_BITS_PER_SYMBOL);
        w_o_off    = 1'b1;
        w_o_last   = (w_pay_len_n == '0) &&
                     (({1'b0, w_seg_cnt_n} + 1'b1) ==
                      {1'b0, w_hdr_len_n});
      end
      S_PAYLOAD: begin
        w_o_valid  = 1'b1;
        w_o_source = 2'd1;
        w_o_bps    = w_bps_n;
        w_o_off    = w_off_n;
        w_o_last   = (({1'b0, w_pay_cnt_n} + 1'b1) ==
                      {1'b0, w_pay_len_n});
      end
      S_PILOT: begin
        w_o_valid  = 1'b1;
        w_o_source = 2'd2;
        w_o_bps    = BW'(PILOT_BITS_PER_SYMBOL);
        w_o_off    = 1'b0;
      end
      default: begin
        w_o_valid  = 1'b0;
      end
    endcase
  end

  // State, counters, latched config and registered outputs
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state      <= S_IDLE;
      r_bps        <= '0;
      r_off        <= 1'b0;
      r_hdr_len    <= '0;
      r_pay_len    <= '0;
      r_itv        <= '0;
      r_pil_len    <= '0;
      r_pil_en     <= 1'b0;
      r_cont       <= 1'b0;
      r_seg_cnt    <= '0;
      r_pay_cnt    <= '0;
      r_itv_cnt    <= '0;
      r_first      <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_sym_source <= 2'd0;
      r_sym_bps    <= '0;
      r_sym_off    <= 1'b0;
      r_sym_first  <= 1'b0;
      r_sym_last   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_error  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_bps        <= w_bps_n;
      r_off        <= w_off_n;
      r_hdr_len    <= w_hdr_len_n;
      r_pay_len    <= w_pay_len_n;
      r_itv        <= w_itv_n;
      r_pil_len    <= w_pil_len_n;
      r_pil_en     <= w_pil_en_n;
      r_cont       <= w_cont_n;
      r_seg_cnt    <= w_seg_cnt_n;
      r_pay_cnt    <= w_pay_cnt_n;
      r_itv_cnt    <= w_itv_cnt_n;
      r_first      <= w_first_n;
      r_sym_valid  <= w_o_valid;
      r_sym_source <= w_o_source;
      r_sym_bps    <= w_o_bps;
      r_sym_off    <= w_o_off;
      r_sym_first  <= w_o_valid && w_first_n;
      r_sym_last   <= w_o_valid && w_o_last;
      r_busy       <= (w_state_n != S_IDLE);
      r_frame_done <= (w_state_n == S_DONE);
      r_cfg_error  <= w_err_n;
    end
  end

  assign sym_valid           = r_sym_valid;
  assign sym_source          = r_sym_source;
  assign sym_bits_per_symbol = r_sym_bps;
  assign sym_offset_enable   = r_sym_off;
  assign sym_first           = r_sym_first;
  assign sym_last            = r_sym_last;
  assign busy                = r_busy;
  assign frame_done          = r_frame_done;
  assign cfg_error           = r_cfg_error;

endmodule

// File: doc/apsk_frame_sequencer.md
Name: apsk_frame_sequencer

Overview:
Per-symbol scheduler that sits between the APSK modulator control registers and the APSK modulator datapath. For each frame it sequences header, payload and pilot segments. For every symbol it issues the modulation order, the offset-symbol enable and the source selection over a valid/ready handshake, so the modulator and the bit-source mux change mode on exact symbol boundaries.

Parameters:
BITS_PER_SYMBOL_WIDTH, 4, width of the bits-per-symbol fields (matches the control block)
LENGTH_WIDTH, 16, width of the segment length and interval counters
MAX_BITS_PER_SYMBOL, 5, largest legal payload bits-per-symbol (32APSK)
HEADER_BITS_PER_SYMBOL, 1, modulation order for header symbols (pi/2 BPSK)
PILOT_BITS_PER_SYMBOL, 2, modulation order for pilot symbols

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
cfg_bits_per_symbol  in  BITS_PER_SYMBOL_WIDTH  payload modulation order
cfg_offset_symbol_enable  in  1  payload offset-symbol enable
cfg_header_length  in  LENGTH_WIDTH  header symbols per frame
cfg_payload_length  in  LENGTH_WIDTH  payload symbols per frame
cfg_pilot_interval  in  LENGTH_WIDTH  payload symbols between pilot blocks
cfg_pilot_length  in  LENGTH_WIDTH  symbols per pilot block
cfg_pilots_enable  in  1  pilot insertion on/off
cfg_continuous  in  1  restart automatically after each frame
start  in  1  begin a frame (sampled in IDLE only)
abort  in  1  synchronous abort to IDLE
sym_ready  in  1  modulator accepts current symbol
sym_valid  out  1  symbol descriptor valid
sym_source  out  2  0 header, 1 payload, 2 pilot
sym_bits_per_symbol  out  BITS_PER_SYMBOL_WIDTH  modulation order for this symbol
sym_offset_enable  out  1  offset-symbol enable for this symbol
sym_first  out  1  first symbol of frame
sym_last  out  1  last symbol of frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle end-of-frame pulse
cfg_error  out  1  one-cycle illegal-configuration pulse

Behaviour:
- Reset (asynchronous, any time including mid-frame): state IDLE, all counters 0, every output 0.
- States: IDLE, HEADER, PAYLOAD, PILOT, DONE.
- Accepted symbol = sym_valid && sym_ready. Counters advance only on an accepted symbol.
- While sym_valid=1 and sym_ready=0, all sym_* outputs hold stable. The only exceptions are abort and reset.
- IDLE, start=1, legal config:
  - latch all cfg_* inputs; the latched copy is used for the whole frame.
  - next state: HEADER if header_length>0; else PAYLOAD if payload_length>0; else DONE.
- Illegal config: cfg_bits_per_symbol==0, cfg_bits_per_symbol>MAX_BITS_PER_SYMBOL, or (pilots_enable && (interval==0 || pilot_length==0)). Result: cfg_error pulses for 1 cycle and the block stays in IDLE.
- start outside IDLE is ignored.
- sym_valid=1 in HEADER, PAYLOAD and PILOT; 0 in IDLE and DONE. The first symbol is valid one cycle after start is sampled.
- HEADER: source 0, bps=HEADER_BITS_PER_SYMBOL, offset=1. After header_length accepted symbols: PAYLOAD, or DONE if payload_length==0.
- PAYLOAD: source 1, latched bps and offset. Track the total payload count and the count since the last pilot block. When the in-interval count reaches pilot_interval, pilots_enable=1 and payload remains: go to PILOT. When the total reaches payload_length: go to DONE. No pilot block follows the final payload symbol.
- PILOT: source 2, bps=PILOT_BITS_PER_SYMBOL, offset=0. After pilot_length accepted symbols, return to PAYLOAD with the in-interval count cleared.
- sym_first=1 only on the first symbol of the frame. sym_last=1 only on the final symbol. Both are qualified by sym_valid.
- DONE lasts exactly 1 cycle with frame_done=1. Next state: if latched continuous=1 and current cfg inputs are legal, relatch cfg and enter the first non-empty segment (no idle gap beyond the DONE cycle); otherwise IDLE.
- A relatch with illegal cfg pulses cfg_error and goes to IDLE.
- abort=1 in any non-IDLE state: IDLE on the next edge, sym_valid drops immediately, no frame_done. abort has priority over start and handshake.
- Counter widths are LENGTH_WIDTH; lengths up to 2^LENGTH_WIDTH-1 are legal, with no wrap inside a segment.

Test Plan:
- Config bps=4, offset=0, header=4, payload=10, interval=4, pilot_len=2, pilots on; sym_ready=1; start pulse. Required source sequence (18 symbols): 0×4, 1×4, 2×2, 1×4, 2×2, 1×2. Header bps=1/off=1, payload bps=4/off=0, pilot bps=2/off=0. first on symbol 1, last on symbol 18, frame_done one cycle later.
- payload=8, interval=4, header=0: sequence 1×4, 2×2, 1×4 then DONE, with no trailing pilot. pilots off, same config: 1×8.
- Backpressure: sym_ready toggling 1,0,0,1 (repeat) on the first test. All sym_* outputs hold while ready=0, and the total accepted count is still 18.
- header=0, payload=0, start: DONE immediately, frame_done pulse, sym_valid never 1. bps=6 with start: cfg_error pulse, busy stays 0.
- continuous=1, header=2, payload=2, pilots off: frames repeat with exactly one sym_valid=0 (DONE) cycle between them. Changing bps to 2 mid-frame affects only the next frame.
- abort on payload symbol 3: IDLE next cycle, no frame_done. Async reset asserted mid-pilot: all outputs 0 without waiting for a clock edge. A new start after either runs a complete frame.
